// File: rtl/izh_synapse_current.sv
// Exponentially decaying synapse: latches presynaptic spike edges per channel,
// then on each tick runs decay followed by a one-channel-per-cycle weighted accumulate.

module izh_syn_chan (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               spike_in,
  input  logic               w_we,
  input  logic signed [31:0] w_data,
  input  logic               clr,
  output logic               pending,
  output logic signed [31:0] weight
);
  logic               spike_prev_q, spike_prev_d;
  logic               pending_q, pending_d;
  logic signed [31:0] weight_q, weight_d;
  logic               edge_det;

  always_comb begin
    edge_det     = spike_in & ~spike_prev_q;
    spike_prev_d = spike_in;
    // a fresh edge in the scan cycle wins over the clear
    pending_d    = (pending_q & ~clr) | edge_det;
    weight_d     = w_we ? w_data : weight_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_prev_q <= 1'b0;
      pending_q    <= 1'b0;
      weight_q     <= '0;
    end else begin
      spike_prev_q <= spike_prev_d;
      pending_q    <= pending_d;
      weight_q     <= weight_d;
    end
  end

  assign pending = pending_q;
  assign weight  = weight_q;
endmodule

module izh_synapse_current #(
  parameter int                 N_INPUTS    = 4,
  parameter int                 DECAY_SHIFT = 3,
  parameter logic signed [31:0] CURRENT_MAX = 32'sd6553600,
  parameter logic signed [31:0] CURRENT_MIN = -32'sd6553600
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_INPUTS-1:0]         spike_in,
  input  logic                        tick,
  input  logic                        w_we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic signed [31:0]          w_data,
  output logic signed [31:0]          current,
  output logic                        current_valid,
  output logic                        busy,
  output logic                        tick_overrun
);
  localparam int IDX_W = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic signed [32:0] MAX33 = {CURRENT_MAX[31], CURRENT_MAX};
  localparam logic signed [32:0] MIN33 = {CURRENT_MIN[31], CURRENT_MIN};
  localparam logic signed [31:0] SNAP  = 32'sd1 <<< DECAY_SHIFT;

  typedef enum logic [1:0] {IDLE, DECAY, ACCUM, DONE} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [31:0]           acc_q, acc_d;
  logic signed [31:0]           current_q, current_d;
  logic                         cur_vld_q, cur_vld_d;
  logic                         overrun_q, overrun_d;

  logic [N_INPUTS-1:0]             chan_we, chan_clr, pending;
  logic [N_INPUTS-1:0][31:0]       weight;
  logic signed [31:0]              dec, w_sel;
  logic signed [32:0]              sum;
  logic                            snap, scan;

  assign scan = (state_q == ACCUM);

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
    // out-of-range addresses match no channel and are dropped
    assign chan_we[i]  = w_we && (w_addr == IDX_W'(i));
    assign chan_clr[i] = scan && (idx_q == IDX_W'(i));
    izh_syn_chan u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .spike_in(spike_in[i]),
      .w_we    (chan_we[i]),
      .w_data  (w_data),
      .clr     (chan_clr[i]),
      .pending (pending[i]),
      .weight  (weight[i])
    );
  end

  always_comb begin
    dec   = acc_q >>> DECAY_SHIFT;
    // values that would crawl by -1 forever (|acc| < 2^shift) snap to zero
    snap  = (acc_q < SNAP) && (acc_q > -SNAP);
    w_sel = weight[idx_q];
    sum   = {acc_q[31], acc_q} + {w_sel[31], w_sel};

    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    current_d = current_q;
    cur_vld_d = 1'b0;
    overrun_d = overrun_q | (tick && (state_q != IDLE));

    case (state_q)
      IDLE: if (tick) state_d = DECAY;
      DECAY: begin
        acc_d   = snap ? 32'sd0 : acc_q - dec;
        idx_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (pending[idx_q]) begin
          if (sum > MAX33)      acc_d = CURRENT_MAX;
          else if (sum < MIN33) acc_d = CURRENT_MIN;
          else                  acc_d = sum[31:0];
        end
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        current_d = acc_q;
        cur_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      current_q <= '0;
      cur_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      current_q <= current_d;
      cur_vld_q <= cur_vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign current       = current_q;
  assign current_valid = cur_vld_q;
  assign busy          = (state_q != IDLE);
  assign tick_overrun  = overrun_q;
endmodule

// File: tb/tb_izh_synapse_current.sv
// Directed bench for izh_synapse_current with hand-computed Q16.16 expectations.

module tb_izh_synapse_current;
  logic               clk = 1'b0;
  logic               reset_n;
  logic [3:0]         spike_in;
  logic               tick;
  logic               w_we;
  logic [1:0]         w_addr;
  logic signed [31:0] w_data;
  logic signed [31:0] current;
  logic               current_valid;
  logic               busy;
  logic               tick_overrun;

  int checks = 0;
  int errors = 0;

  izh_synapse_current dut (
    .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .tick(tick),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .current(current),
    .current_valid(current_valid), .busy(busy), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; spike_in = '0; tick = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic write_w(input logic [1:0] a, input logic signed [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    step();
    w_we = 1'b0;
  endtask

  task automatic pulse_spike(input logic [3:0] m);
    spike_in = spike_in | m;
    step();
    spike_in = spike_in & ~m;
    step();
  endtask

  // waits for the current_valid pulse; lat = cycles counted, -1 on timeout
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (current_valid) begin lat = c; break; end
    end
  endtask

  task automatic run_tick(output int lat);
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_valid(lat);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; spike_in = '0; tick = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    step();
    checks++;
    if (current !== 32'sd0 || current_valid !== 1'b0 || busy !== 1'b0 || tick_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: current=%0d valid=%b busy=%b ovr=%b, want 0/0/0/0",
               current, current_valid, busy, tick_overrun);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_event();
    int lat;
    do_reset();
    write_w(2'd0, 32'sd131072);
    pulse_spike(4'b0001);
    run_tick(lat);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL single_latency: got %0d want 6", lat); end
    checks++;
    if (current !== 32'sd131072) begin errors++; $display("FAIL single_current: got %0d want 131072", current); end
    step();
    checks++;
    if (current_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b want 0", current_valid); end
    run_tick(lat);
    checks++;
    if (current !== 32'sd114688) begin errors++; $display("FAIL single_decay: got %0d want 114688", current); end
  endtask

  task automatic test_inhibition();
    int lat;
    logic signed [31:0] exp_v, prev;
    do_reset();
    write_w(2'd1, -32'sd65536);
    pulse_spike(4'b0010);
    run_tick(lat);
    checks++;
    if (current !== -32'sd65536) begin errors++; $display("FAIL inhib_first: got %0d want -65536", current); end
    run_tick(lat);
    checks++;
    if (current !== -32'sd57344) begin errors++; $display("FAIL inhib_decay: got %0d want -57344", current); end
    exp_v = -32'sd57344;
    for (int k = 0; k < 120 && exp_v != 0; k++) begin
      prev = exp_v;
      if (exp_v > -32'sd8) exp_v = 0;
      else exp_v = exp_v - (exp_v >>> 3);
      run_tick(lat);
      checks++;
      if (current !== exp_v || current < prev) begin
        errors++;
        $display("FAIL inhib_walk: got %0d want %0d (prev %0d)", current, exp_v, prev);
      end
    end
    run_tick(lat);
    run_tick(lat);
    checks++;
    if (current !== 32'sd0) begin errors++; $display("FAIL inhib_zero_hold: got %0d want 0", current); end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    for (int i = 0; i < 4; i++) write_w(2'(i), 32'sd4000000);
    pulse_spike(4'b1111);
    run_tick(lat);
    checks++;
    if (current !== 32'sd6553600) begin errors++; $display("FAIL sat_pos: got %0d want 6553600", current); end
    for (int i = 0; i < 4; i++) write_w(2'(i), -32'sd4000000);
    pulse_spike(4'b1111);
    run_tick(lat);
    checks++;
    if (current !== -32'sd6553600) begin errors++; $display("FAIL sat_neg: got %0d want -6553600", current); end
  endtask

  task automatic test_edges();
    int lat;
    do_reset();
    write_w(2'd2, 32'sd65536);
    spike_in[2] = 1'b1;
    step();
    run_tick(lat);
    checks++;
    if (current !== 32'sd65536) begin errors++; $display("FAIL held_first: got %0d want 65536", current); end
    run_tick(lat);
    checks++;
    if (current !== 32'sd57344) begin errors++; $display("FAIL held_second: got %0d want 57344", current); end
    run_tick(lat);
    checks++;
    if (current !== 32'sd50176) begin errors++; $display("FAIL held_third: got %0d want 50176", current); end
    spike_in[2] = 1'b0;
    step();
    pulse_spike(4'b0100);
    pulse_spike(4'b0100);
    run_tick(lat);
    checks++;
    if (current !== 32'sd109440) begin errors++; $display("FAIL merged_edges: got %0d want 109440", current); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    write_w(2'd0, 32'sd65536);
    pulse_spike(4'b0001);
    run_tick(lat);
    checks++;
    if (current !== 32'sd65536) begin errors++; $display("FAIL b2b_first: got %0d want 65536", current); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || tick_overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b ovr=%b want 1/0", busy, tick_overrun);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 6 || current !== 32'sd57344) begin
      errors++; $display("FAIL b2b_second: lat=%0d current=%0d want 6/57344", lat, current);
    end
    tick = 1'b1; step(); tick = 1'b0;
    step();
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (tick_overrun !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL overrun_set: ovr=%b busy=%b want 1/1", tick_overrun, busy);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 4 || current !== 32'sd50176) begin
      errors++; $display("FAIL overrun_pass: lat=%0d current=%0d want 4/50176", lat, current);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || tick_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_dropped: busy=%b ovr=%b want 0/1", busy, tick_overrun);
    end
  endtask

  task automatic test_weight_during_scan();
    int lat;
    do_reset();
    write_w(2'd3, 32'sd65536);
    pulse_spike(4'b1000);
    tick = 1'b1; step(); tick = 1'b0;
    repeat (4) step();
    write_w(2'd3, 32'sd131072);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || current !== 32'sd65536) begin
      errors++; $display("FAIL wr_scan_old: lat=%0d current=%0d want 1/65536", lat, current);
    end
    pulse_spike(4'b1000);
    run_tick(lat);
    checks++;
    if (current !== 32'sd188416) begin errors++; $display("FAIL wr_scan_new: got %0d want 188416", current); end
  endtask

  task automatic test_reset_mid_accum();
    int lat;
    do_reset();
    write_w(2'd0, 32'sd65536);
    pulse_spike(4'b0001);
    run_tick(lat);
    checks++;
    if (current !== 32'sd65536) begin errors++; $display("FAIL rst_pre: got %0d want 65536", current); end
    write_w(2'd1, 32'sd65536);
    pulse_spike(4'b0011);
    tick = 1'b1; step(); tick = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (current !== 32'sd0 || busy !== 1'b0 || current_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: current=%0d busy=%b valid=%b want 0/0/0", current, busy, current_valid);
    end
    step();
    reset_n = 1'b1;
    step();
    pulse_spike(4'b0001);
    run_tick(lat);
    checks++;
    if (lat !== 6 || current !== 32'sd0) begin
      errors++; $display("FAIL rst_post: lat=%0d current=%0d want 6/0", lat, current);
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_inhibition();
    test_saturation();
    test_edges();
    test_back_to_back();
    test_weight_during_scan();
    test_reset_mid_accum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/izh_synapse_current.md
# izh_synapse_current

Exponentially decaying synapse that converts presynaptic spike events into a Q16.16 synaptic current for an Izhikevich neuron's `current` input. It has N presynaptic spike inputs, each with a programmable signed weight. On every `tick` it runs a sequential decay-then-accumulate pass and updates a held current register. It sits between upstream neurons' `spike` outputs and a downstream neuron.

## Interface
- `N_INPUTS`, default 4: number of presynaptic channels (2..16).
- `DECAY_SHIFT`, default 3: per-tick decay, I -= I >>> DECAY_SHIFT (1..15).
- `CURRENT_MAX`, default 32'sd6553600: upper saturation bound (+100.0, Q16.16).
- `CURRENT_MIN`, default -32'sd6553600: lower saturation bound (-100.0, Q16.16).

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `spike_in`  in  N_INPUTS  presynaptic spike levels; each rising edge is one event.
- `tick`  in  1  single-cycle update strobe.
- `w_we`  in  1  weight write enable.
- `w_addr`  in  clog2(N_INPUTS)  weight index.
- `w_data`  in  32  signed Q16.16 weight.
- `current`  out  32  signed Q16.16 synaptic current (registered).
- `current_valid`  out  1  one-cycle pulse when `current` updates.
- `busy`  out  1  high while the FSM is not in IDLE.
- `tick_overrun`  out  1  sticky; set when `tick` arrives while busy.

## Operation
- **Reset values:** `current`=0, internal accumulator `acc`=0, all weights=0, pending bits=0, `spike_prev`=0, `current_valid`=0, `busy`=0, `tick_overrun`=0, state IDLE.
- **Edge detect:** every cycle, `spike_prev` <= `spike_in`.
  - `spike_in[i] & ~spike_prev[i]` sets `pending[i]`.
  - A level held high produces one event.
  - A second edge on an already-pending channel is merged. `pending` is a bit, not a counter.
- **Weights:** register file. When `w_we`=1, `weight[w_addr]` <= `w_data` at the clock edge, in any state.
  - A read of the same index in the same cycle returns the old weight.
  - Out-of-range `w_addr` is ignored.
- **IDLE:**
  - `tick`=1 -> DECAY.
  - Any other input stays in IDLE.
- **DECAY:**
  - d = `acc` >>> DECAY_SHIFT (arithmetic shift).
  - If d == 0, `acc` <= 0. Magnitudes below 2^DECAY_SHIFT LSB snap to zero, including negative values where d = -1 and |acc| < 2^DECAY_SHIFT.
  - Otherwise `acc` <= `acc` - d.
  - Next state ACCUM with idx=0.
- **ACCUM (one channel per cycle):**
  - If `pending[idx]`: `acc` <= sat(`acc` + `weight[idx]`), where the sum is computed at 33 bits and clamped to [CURRENT_MIN, CURRENT_MAX]. Clear `pending[idx]`.
  - If a new edge on channel idx occurs in the same cycle, set wins and the bit stays 1. That event is consumed on the next tick.
  - idx == N_INPUTS-1 -> DONE; otherwise idx+1.
- **DONE:**
  - `current` <= `acc`.
  - `current_valid` <= 1 for one cycle.
  - -> IDLE.
- **Ticks while busy:** `tick` in any non-IDLE state is dropped and sets `tick_overrun`. Only reset clears it.
- **Reset mid-pass:** returns everything to reset values immediately, including `current`=0. Partial accumulation is discarded.

## Timing
- Tick sampled at edge E0.
  - DECAY executes at E1.
  - Channels 0..N-1 accumulate at E2..E(N+1).
  - `current`/`current_valid` update at E(N+2).
  - Latency is N_INPUTS+2 cycles (6 for the default).
- `busy` is high for the N_INPUTS+2 cycles after E0, and low in the cycle where `current_valid`=1.
  - A `tick` in that cycle is accepted with no overrun.
- Spike edges are registered one cycle after `spike_in` rises.
  - An edge must be visible at least one cycle before channel idx is scanned to count in that pass.
- `current` is stable between updates, so the downstream neuron may sample it every cycle.

## Test plan
- **Single event:** `weight[0]`=131072, pulse `spike_in[0]`, then `tick` -> after 6 cycles `current`=131072 and `current_valid` pulses once; the next `tick` with no spikes -> 114688.
- **Inhibition and negative decay:** `weight[1]`=-65536, spike, tick -> -65536; tick -> -57344; repeat ticks -> monotonically toward 0, reaching exactly 0 and staying there.
- **Saturation:** all four weights=4000000, all spike, tick -> `current`=6553600; weights=-4000000 -> `current`=-6553600, with no wraparound.
- **Edge semantics:** hold `spike_in[2]` high across 3 ticks with `weight[2]`=65536 -> only the first pass adds. Two edges before one tick -> adds once.
- **Overrun and boundaries:**
  - `tick` at E0+2 -> ignored, `tick_overrun`=1.
  - `tick` in the `current_valid` cycle -> accepted, overrun unchanged.
  - Weight write to the channel being scanned -> old weight used.
- **Reset mid-ACCUM:** assert `reset_n`=0 during idx=2 -> `current`=0, `busy`=0, pending and weights cleared; post-reset tick -> `current`=0.
